// File: rtl/typecm_tx_sched.sv
// ============================================================================
// Module   : typecm_tx_sched
// Purpose  : Transmit scheduler for the type-C/M link. Arbitrates between a
//            response request (highest priority) and three report requests
//            (round-robin), then drives one packet at a time to typecm_tx
//            using an fs/fd handshake.
// Options  : TYPECM_TX_SCHED_TIMEOUT_EN - adds a SEND-state timeout of
//            TMO_CYC cycles that raises err and re-arbitrates the request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module typecm_tx_sched #(
  parameter logic [15:0] TMO_CYC = 16'd4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rsp_req,
  input  logic [1:0] rsp_code,
  output logic       rsp_done,
  input  logic [2:0] rpt_req,
  output logic [2:0] rpt_done,
  output logic [3:0] btype,
  output logic       fs,
  input  logic       fd,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_SEND = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [3:0] c_btype_init = 4'b0000;
  localparam logic [3:0] c_btype_rpt0 = 4'b0101;

  state_t     r_state;
  logic [3:0] r_btype;
  logic       r_fs;
  logic       r_busy;
  logic       r_rsp_done;
  logic [2:0] r_rpt_done;
  logic       r_is_rsp;   // packet in flight is the response, not a report
  logic [1:0] r_grant;    // report index of the packet in flight
  logic [1:0] r_ptr;      // round-robin search start

  logic       w_rsp_valid;
  logic       w_rr_hit;
  logic [1:0] w_rr_idx;

`ifdef TYPECM_TX_SCHED_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_err;
  assign err = r_err;
`else
  // Timeout hardware is absent; keep the parameter referenced for lint.
  logic w_unused_tmo;
  assign w_unused_tmo = ^TMO_CYC;
  assign err = 1'b0;
`endif

  assign btype    = r_btype;
  assign fs       = r_fs;
  assign busy     = r_busy;
  assign rsp_done = r_rsp_done;
  assign rpt_done = r_rpt_done;

  // Response validity and round-robin report pick starting at r_ptr.
  always_comb begin
    w_rsp_valid = rsp_req && (rsp_code != 2'b00);
    w_rr_hit    = 1'b0;
    w_rr_idx    = 2'd0;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int i = 2; i >= 0; i--) begin
      int j;
      j = (int'(r_ptr) + i) % 3;
      if (rpt_req[j]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = 2'(j);
      end
    end
  end

  // Scheduler state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_btype    <= c_btype_init;
      r_fs       <= 1'b0;
      r_busy     <= 1'b0;
      r_rsp_done <= 1'b0;
      r_rpt_done <= 3'b000;
      r_is_rsp   <= 1'b0;
      r_grant    <= 2'd0;
      r_ptr      <= 2'd0;
`ifdef TYPECM_TX_SCHED_TIMEOUT_EN
      r_cnt      <= 16'd0;
      r_err      <= 1'b0;
`endif
    end else begin
      // Completion pulses last a single cycle.
      r_rsp_done <= 1'b0;
      r_rpt_done <= 3'b000;
`ifdef TYPECM_TX_SCHED_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_rsp_valid) begin
            r_state  <= S_PREP;
            r_busy   <= 1'b1;
            r_is_rsp <= 1'b1;
            r_btype  <= {2'b00, rsp_code};
          end else if (w_rr_hit) begin
            r_state  <= S_PREP;
            r_busy   <= 1'b1;
            r_is_rsp <= 1'b0;
            r_grant  <= w_rr_idx;
            r_btype  <= c_btype_rpt0 + {2'b00, w_rr_idx};
          end
        end
        S_PREP: begin
          r_state <= S_SEND;
          r_fs    <= 1'b1;
`ifdef TYPECM_TX_SCHED_TIMEOUT_EN
          r_cnt   <= 16'd0;
`endif
        end
        S_SEND: begin
          // fd takes precedence over an expiring timeout.
          if (fd) begin
            r_state <= S_DONE;
            r_fs    <= 1'b0;
            if (r_is_rsp) begin
              r_rsp_done <= 1'b1;
            end else begin
              r_rpt_done <= 3'b001 << r_grant;
            end
`ifdef TYPECM_TX_SCHED_TIMEOUT_EN
          end else if (r_cnt == TMO_CYC - 16'd1) begin
            r_state <= S_ERR;
            r_fs    <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
`endif
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_btype <= c_btype_init;
          if (!r_is_rsp) begin
            r_ptr <= (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;
          end
        end
        S_ERR: begin
          // Request stays pending; pointer untouched so it re-arbitrates.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_btype <= c_btype_init;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_fs    <= 1'b0;
          r_btype <= c_btype_init;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_typecm_tx_sched.sv
// ============================================================================
// Module   : tb_typecm_tx_sched
// Purpose  : Randomized self-checking bench for typecm_tx_sched against a
//            packet-level reference model (priority + round-robin pointer).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_typecm_tx_sched;

`ifdef TYPECM_TX_SCHED_TIMEOUT_EN
  localparam int c_tmo = 8;
`else
  localparam int c_tmo = 0;
`endif

  logic       clk;
  logic       rst;
  logic       rsp_req;
  logic [1:0] rsp_code;
  logic       rsp_done;
  logic [2:0] rpt_req;
  logic [2:0] rpt_done;
  logic [3:0] btype;
  logic       fs;
  logic       fd;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  typecm_tx_sched #(.TMO_CYC(16'd8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rsp_req  (rsp_req),
    .rsp_code (rsp_code),
    .rsp_done (rsp_done),
    .rpt_req  (rpt_req),
    .rpt_done (rpt_done),
    .btype    (btype),
    .fs       (fs),
    .fd       (fd),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs expected in IDLE (also after reset).
  task automatic check_idle(input string tag);
    check({tag, ".busy"}, {3'b0, busy}, 4'h0);
    check({tag, ".fs"}, {3'b0, fs}, 4'h0);
    check({tag, ".btype"}, btype, 4'h0);
    check({tag, ".rsp_done"}, {3'b0, rsp_done}, 4'h0);
    check({tag, ".rpt_done"}, {1'b0, rpt_done}, 4'h0);
    check({tag, ".err"}, {3'b0, err}, 4'h0);
  endtask

  // Reference model state: next report index the search starts from.
  int         m_ptr = 0;
  logic       keep = 1'b0;
  logic       s_rsp_req;
  logic [1:0] s_rsp_code;
  logic [2:0] s_rpt_req;

  task automatic scramble();
    rsp_req  = 1'($urandom);
    rsp_code = 2'($urandom);
    rpt_req  = 3'($urandom);
  endtask

  task automatic do_iter();
    bit         is_rsp;
    bit         granted;
    int         idx;
    logic [3:0] exp_bt;
    int         w;
    bit         do_rst;

    @(negedge clk);
    if (keep) begin
      rsp_req = s_rsp_req; rsp_code = s_rsp_code; rpt_req = s_rpt_req;
      keep = 1'b0;
    end else begin
      scramble();
      if ($urandom % 3 == 0) rpt_req = 3'b000;
    end
    fd = 1'($urandom);  // fd while idle must be ignored
    s_rsp_req = rsp_req; s_rsp_code = rsp_code; s_rpt_req = rpt_req;

    // Model: valid response wins; otherwise first set report from m_ptr.
    granted = 1'b0; is_rsp = 1'b0; idx = 0; exp_bt = 4'h0;
    if (rsp_req && rsp_code != 2'b00) begin
      granted = 1'b1; is_rsp = 1'b1; exp_bt = {2'b00, rsp_code};
    end else begin
      for (int k = 0; k < 3; k++) begin
        int j;
        j = (m_ptr + k) % 3;
        if (!granted && rpt_req[j]) begin
          granted = 1'b1; idx = j;
        end
      end
      if (granted) exp_bt = 4'd5 + 4'(idx);
    end

    @(posedge clk); #1;
    if (!granted) begin
      check_idle("idle");
      return;
    end
    check("prep.busy", {3'b0, busy}, 4'h1);
    check("prep.fs", {3'b0, fs}, 4'h0);
    check("prep.btype", btype, exp_bt);

    @(negedge clk);
    scramble();
    fd = 1'($urandom);  // fd in PREP must be ignored
    @(posedge clk); #1;
    check("send.fs_rise", {3'b0, fs}, 4'h1);
    check("send.btype", btype, exp_bt);

    w = $urandom_range(0, 10);
    do_rst = ($urandom % 12 == 0);
    for (int c = 1; c <= w + 1; c++) begin
      @(negedge clk);
      if (do_rst && c == 2) begin
        rst = 1'b0;
        #1;
        check_idle("rst_send");
        @(negedge clk);
        rsp_req = 1'b0; rpt_req = 3'b000; fd = 1'b0;
        rst = 1'b1;
        m_ptr = 0;
        keep = 1'b1;  // still-held request must be re-sent
        return;
      end
      scramble();
      fd = (c == w + 1);
      @(posedge clk); #1;
      if (fd) begin
        check("done.fs", {3'b0, fs}, 4'h0);
        check("done.rsp_done", {3'b0, rsp_done}, {3'b0, is_rsp});
        check("done.rpt_done", {1'b0, rpt_done}, is_rsp ? 4'h0 : 4'(1 << idx));
        check("done.btype", btype, exp_bt);
        check("done.err", {3'b0, err}, 4'h0);
        if (!is_rsp) m_ptr = (idx + 1) % 3;
        break;
      end else if (c_tmo != 0 && c == c_tmo) begin
        check("tmo.err", {3'b0, err}, 4'h1);
        check("tmo.fs", {3'b0, fs}, 4'h0);
        check("tmo.done", {rsp_done, rpt_done}, 4'h0);
        keep = 1'b1;  // request stays pending and is retried
        break;
      end else begin
        check("send.fs_hold", {3'b0, fs}, 4'h1);
        check("send.no_done", {rsp_done, rpt_done}, 4'h0);
        check("send.btype_hold", btype, exp_bt);
      end
    end

    @(negedge clk);
    fd = 1'b0;
    scramble();  // DONE/ERR cycle does not sample requests
    @(posedge clk); #1;
    check_idle("back_idle");
  endtask

  initial begin
    rst = 1'b0; rsp_req = 1'b0; rsp_code = 2'b00; rpt_req = 3'b000; fd = 1'b0;
    #12;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 400; n++) do_iter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
